// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential instruction fetch front end feeding decode through a DEPTH-entry {pc, instr} FIFO.
// Define FETCH_BUFFER_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
`timescale 1ns/1ps
module fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic        fbuf_valid,
   input  logic        fbuf_ready,
   output logic [31:0] fbuf_pc,
   output logic [31:0] fbuf_instr,
   output logic        iram_valid,
   output logic        iram_instr,
   output logic [31:0] iram_addr,
   output logic [31:0] iram_wdata,
   output logic [3:0]  iram_wstrb,
   input  logic [31:0] iram_rdata,
   input  logic        iram_ready
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]   pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          drop;
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   occ;
   logic [AW+1:0] credits_used;
   logic          issue;
   logic          resp_ok;
   logic          push;
   logic          pop;
   logic          fifo_nempty;

   // Credits come from registered occupancy only, so a same-cycle pop never frees one.
   assign credits_used = {1'b0, occ} + {{(AW+1){1'b0}}, inflight};
   assign issue        = rst & ~redir_valid & (credits_used < (AW+2)'(DEPTH));
   assign resp_ok      = iram_ready & inflight & ~drop & ~redir_valid;
   assign fifo_nempty  = (occ != '0);
   assign pop          = fifo_nempty & fbuf_ready & ~redir_valid;

   assign iram_valid = issue;
   assign iram_addr  = pc;
   assign iram_instr = 1'b1;
   assign iram_wdata = '0;
   assign iram_wstrb = '0;

`ifdef FETCH_BUFFER_BYPASS_EN
   logic byp;
   assign byp        = ~fifo_nempty & resp_ok;
   assign fbuf_valid = fifo_nempty | byp;
   assign fbuf_pc    = fifo_nempty ? mem_pc[rd_ptr]    : (byp ? inflight_pc : '0);
   assign fbuf_instr = fifo_nempty ? mem_instr[rd_ptr] : (byp ? iram_rdata  : '0);
   assign push       = resp_ok & ~(byp & fbuf_ready);
`else
   assign fbuf_valid = fifo_nempty;
   assign fbuf_pc    = fifo_nempty ? mem_pc[rd_ptr]    : '0;
   assign fbuf_instr = fifo_nempty ? mem_instr[rd_ptr] : '0;
   assign push       = resp_ok;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         drop        <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occ         <= '0;
      end else if (redir_valid) begin
         pc       <= redir_pc & ~32'h3;
         inflight <= 1'b0;
         drop     <= inflight;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
         end
         // drop only ever covers the single cycle following a redirect.
         drop <= 1'b0;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]    <= inflight_pc;
         mem_instr[wr_ptr] <= iram_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of fetch_buffer against a one-cycle iram responder (rdata = addr ^ 32'hA5A5A5A5).
`timescale 1ns/1ps
module tb_fetch_buffer;
   localparam logic [31:0] K = 32'hA5A5A5A5;
`ifdef FETCH_BUFFER_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        fbuf_valid;
   logic        fbuf_ready;
   logic [31:0] fbuf_pc;
   logic [31:0] fbuf_instr;
   logic        iram_valid;
   logic        iram_instr;
   logic [31:0] iram_addr;
   logic [31:0] iram_wdata;
   logic [3:0]  iram_wstrb;
   logic [31:0] iram_rdata = '0;
   logic        iram_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int nv;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t q[$];

   fetch_buffer #(.DEPTH(4), .RESET_PC(32'h100)) dut (
      .clk(clk), .rst(rst),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .fbuf_valid(fbuf_valid), .fbuf_ready(fbuf_ready),
      .fbuf_pc(fbuf_pc), .fbuf_instr(fbuf_instr),
      .iram_valid(iram_valid), .iram_instr(iram_instr), .iram_addr(iram_addr),
      .iram_wdata(iram_wdata), .iram_wstrb(iram_wstrb),
      .iram_rdata(iram_rdata), .iram_ready(iram_ready)
   );

   always #5 clk = ~clk;

   // iram responder: a request seen mid-cycle is answered in the following cycle.
   initial begin
      logic        pend_v;
      logic [31:0] pend_a;
      forever begin
         @(negedge clk);
         pend_v = iram_valid;
         pend_a = iram_addr;
         @(posedge clk);
         #1;
         iram_ready = pend_v;
         iram_rdata = pend_a ^ K;
      end
   end

   always @(negedge clk)
      if (rst && !redir_valid && fbuf_valid && fbuf_ready)
         q.push_back('{pc: fbuf_pc, instr: fbuf_instr});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc();
      end
   endtask

   function automatic logic [31:0] q_pc(input int i);
      return (i < q.size()) ? q[i].pc : 32'hDEADDEAD;
   endfunction

   function automatic logic [31:0] q_instr(input int i);
      return (i < q.size()) ? q[i].instr : 32'hDEADDEAD;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; redir_valid = 1'b0; redir_pc = '0; fbuf_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_iram_valid", iram_valid, 32'd0);
      check("rst_iram_addr",  iram_addr,  32'h100);
      check("rst_fbuf_valid", fbuf_valid, 32'd0);
      check("rst_fbuf_pc",    fbuf_pc,    32'h0);
      check("rst_fbuf_instr", fbuf_instr, 32'h0);
      check("rst_iram_instr", iram_instr, 32'd1);
      check("rst_iram_wdata", iram_wdata, 32'h0);
      check("rst_iram_wstrb", iram_wstrb, 32'h0);

      // Stall: decode not ready for 20 cycles.
      cyc();
      rst = 1'b1;
      @(negedge clk);
      nv = 0;
      if (iram_valid) nv++;
      check("c0_iram_valid", iram_valid, 32'd1);
      check("c0_iram_addr",  iram_addr,  32'h100);
      for (int i = 1; i < 20; i++) begin
         cyc();
         @(negedge clk);
         if (iram_valid) nv++;
         if (i == 1) begin
            check("c1_iram_addr",  iram_addr,  32'h104);
            check("c1_fbuf_valid", fbuf_valid, {31'd0, BYP});
            check("c1_fbuf_pc",    fbuf_pc,    BYP ? 32'h100 : 32'h0);
         end
         if (i == 2) begin
            check("c2_fbuf_valid", fbuf_valid, 32'd1);
            check("c2_fbuf_pc",    fbuf_pc,    32'h100);
            check("c2_fbuf_instr", fbuf_instr, 32'h100 ^ K);
         end
      end
      check("stall_issue_cnt",  nv,         32'd4);
      check("stall_iram_valid", iram_valid, 32'd0);
      check("stall_fbuf_valid", fbuf_valid, 32'd1);
      check("stall_head_pc",    fbuf_pc,    32'h100);

      // Release: one instruction per cycle, no gaps.
      cyc();
      fbuf_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("stream_valid", fbuf_valid, 32'd1);
         check("stream_pc",    fbuf_pc,    32'h100 + 32'(4 * k));
         check("stream_instr", fbuf_instr, (32'h100 + 32'(4 * k)) ^ K);
         cyc();
      end

      // Redirect with a fetch in flight and entries buffered.
      redir_valid = 1'b1; redir_pc = 32'h2003; q.delete();
      @(negedge clk);
      check("redir_iram_valid", iram_valid, 32'd0);
      cyc();
      redir_valid = 1'b0;
      @(negedge clk);
      check("redir1_fbuf_valid", fbuf_valid, 32'd0);
      check("redir1_iram_valid", iram_valid, 32'd1);
      check("redir1_iram_addr",  iram_addr,  32'h2000);
      cyc();
      @(negedge clk);
      check("redir2_fbuf_valid", fbuf_valid, {31'd0, BYP});
      check("redir2_fbuf_pc",    fbuf_pc,    BYP ? 32'h2000 : 32'h0);
      cyc();
      run(4);
      check("redir_q0_pc",    q_pc(0),    32'h2000);
      check("redir_q0_instr", q_instr(0), 32'h2000 ^ K);
      check("redir_q1_pc",    q_pc(1),    32'h2004);

      // Back-to-back redirects with decode popping: last one wins.
      redir_valid = 1'b1; redir_pc = 32'h300; q.delete();
      @(negedge clk);
      cyc();
      redir_pc = 32'h400;
      @(negedge clk);
      cyc();
      redir_valid = 1'b0;
      run(6);
      check("b2b_q0_pc", q_pc(0), 32'h400);
      check("b2b_q1_pc", q_pc(1), 32'h404);
      check("b2b_q2_pc", q_pc(2), 32'h408);

      // PC wrap.
      redir_valid = 1'b1; redir_pc = 32'hFFFFFFF8; q.delete();
      run(1);
      redir_valid = 1'b0;
      run(6);
      check("wrap_q0_pc",    q_pc(0),    32'hFFFFFFF8);
      check("wrap_q1_pc",    q_pc(1),    32'hFFFFFFFC);
      check("wrap_q2_pc",    q_pc(2),    32'h00000000);
      check("wrap_q2_instr", q_instr(2), K);

      // Fill to 4, pop one (occ=3, fetch requested), then reset mid-stream.
      redir_valid = 1'b1; redir_pc = 32'h500; fbuf_ready = 1'b0;
      run(1);
      redir_valid = 1'b0;
      run(8);
      fbuf_ready = 1'b1;
      @(negedge clk);
      check("fill_head_pc", fbuf_pc, 32'h500);
      cyc();
      fbuf_ready = 1'b0;
      @(negedge clk);
      check("occ3_iram_valid", iram_valid, 32'd1);
      check("occ3_iram_addr",  iram_addr,  32'h510);
      check("occ3_head_pc",    fbuf_pc,    32'h504);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_iram_valid", iram_valid, 32'd0);
      check("mid_rst_fbuf_valid", fbuf_valid, 32'd0);
      check("mid_rst_fbuf_pc",    fbuf_pc,    32'h0);
      check("mid_rst_iram_addr",  iram_addr,  32'h100);
      cyc();
      rst = 1'b1; fbuf_ready = 1'b1; q.delete();
      @(negedge clk);
      check("rel_iram_valid", iram_valid, 32'd1);
      check("rel_iram_addr",  iram_addr,  32'h100);
      check("rel_fbuf_valid", fbuf_valid, 32'd0);
      cyc();
      @(negedge clk);
      check("rel1_fbuf_valid", fbuf_valid, {31'd0, BYP});
      cyc();
      run(4);
      check("rel_q0_pc",    q_pc(0),    32'h100);
      check("rel_q0_instr", q_instr(0), 32'h100 ^ K);
      check("rel_q1_pc",    q_pc(1),    32'h104);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
